prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sequences the byte-to-word assembly path into the CPU instruction memory. It consumes the 16-bit word stream produced by the serial byte-to-word assembler and interprets the first word after `start` as a length header. It writes the following payload words to consecutive instruction-memory addresses and holds the CPU in reset until the load completes. It sits between the byte-to-word assembler and the instruction RAM write port, and owns the CPU reset.

## Interface
- ADDR_W, 8, instruction-memory address width; maximum payload is 2^ADDR_W words
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ce  in  1  global clock enable; all state advances only when ce=1
- start  in  1  request a (re)load; sampled when ce=1
- word_dv  in  1  word valid strobe from the byte-to-word assembler
- word  in  16  assembled word
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  write data
- cpu_rst  out  1  CPU reset; 1 = CPU held
- busy  out  1  load in progress (HDR, LOAD or CHK)
- done  out  1  program loaded, CPU running
- err  out  1  load aborted

## Operation
- States: IDLE, HDR, LOAD, CHK (present only with the checksum macro), RUN, ERR. All transitions are qualified by ce=1.
- IDLE: cpu_rst=1. start → HDR.
- HDR: on word_dv, len=word.
  - len==0 or len>2^ADDR_W → ERR.
  - Otherwise remaining=len, addr=0 → LOAD.
- LOAD: on each word_dv, the word is written at addr, then addr+1 and remaining-1.
  - On the write with remaining==1 → CHK if checksum is enabled, else → RUN.
- CHK: on word_dv, word==sum → RUN; mismatch → ERR.
- RUN: cpu_rst=0, done=1. start → HDR; cpu_rst reasserts on that same transition.
- ERR: err=1, cpu_rst=1. start → HDR, which clears err.
- start is ignored in HDR, LOAD and CHK. word_dv is ignored in IDLE, RUN and ERR.
- Arithmetic:
  - remaining is ADDR_W+1 bits wide.
  - addr wraps modulo 2^ADDR_W, which is only reachable at len=2^ADDR_W; the last write then lands at 2^ADDR_W-1.
  - sum is a 16-bit modular sum of the payload words, cleared on entry to HDR.

## Timing
- Reset values:
  - cpu_rst=1
  - mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, err=0
  - state IDLE
- All outputs are registered.
- Write path: word_dv accepted in cycle n → mem_we=1 with mem_addr/mem_wdata valid in cycle n+1.
  - mem_we is high for exactly one clk cycle, even if ce drops.
  - mem_addr/mem_wdata hold their values until the next write.
- Last payload word (or checksum word) accepted in cycle n → cpu_rst=0 and done=1 in cycle n+1. The final mem_we also fires in cycle n+1.
- start accepted in cycle n → busy=1 in cycle n+1. A word_dv in cycle n+1 is treated as the header.
- start and word_dv asserted in the same cycle in IDLE/RUN/ERR: the transition to HDR occurs and the word is discarded.
- ce=0 freezes state, counters and the status outputs.
- rst mid-load: immediate return to reset values. The partial memory image is left as written.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHK state exists.
  - One trailing checksum word is required after the payload.
  - A mismatch leads to ERR with cpu_rst held.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no sum register.
  - LOAD goes directly to RUN after the last payload word.
  - err is raised only by a bad header.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, HDR, LOAD, CHK, RUN, ERR)
  - header width constant HDR_W=16
  - checksum width constant CKSUM_W=16
- One sub-module, `loader_cksum`: the 16-bit accumulator with clear and add-enable ports. It is instantiated only under LOADER_CHECKSUM_EN.
- The byte-to-word assembler is instantiated beside this block, not inside it.

## Test plan
- All scenarios use ADDR_W=4, ce=1 unless stated, and checksum enabled unless stated.
- Reset, then start, then words 0x0003, 0x1111, 0x2222, 0x3333, 0x6666:
  - writes at addr 0/1/2 with the payload data
  - then done=1, cpu_rst=0, err=0
- Same sequence with final word 0x6667 → three writes occur, then err=1 and cpu_rst=1. A following start clears err and busy=1.
- Header 0x0000, or header 0x0011 (>16) → err=1, no mem_we.
- Header 0x0010 followed by 16 words → last write at addr 15, no wrap write at addr 0. Repeat with the macro undefined and no checksum word → done=1.
- ce toggling 1/0 every cycle during the load → identical writes and final state to the ce=1 run; word_dv with ce=0 is not accepted.
- rst asserted after the second payload word → all outputs return to reset values at once. A new start plus a full stream loads correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// FSM encoding is fixed so that legacy debug taps keep their state values.
package loader_pkg;

    localparam int HDR_W   = 16;
    localparam int CKSUM_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_CHK  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

endpackage

// File: rtl/loader_cksum.sv
// 16-bit modular accumulator of payload words; one-cycle update, clear wins over add.
// No backpressure: it adds whenever add_i is high.
module loader_cksum
    import loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               add_i,
    input  logic [CKSUM_W-1:0] data_i,
    output logic [CKSUM_W-1:0] sum_o
);

    logic [CKSUM_W-1:0] sum_q;
    logic [CKSUM_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length header then payload into instruction RAM, write one cycle after accept; no backpressure.
// Trailing checksum word verified when LOADER_CHECKSUM_EN is defined.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              start,
    input  logic              word_dv,
    input  logic [HDR_W-1:0]  word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [HDR_W-1:0]  mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [HDR_W-1:0] MAX_LEN = HDR_W'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]  REM_ONE = (ADDR_W + 1)'(1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [HDR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, busy_q, done_q, err_q;

`ifdef LOADER_CHECKSUM_EN
    logic [CKSUM_W-1:0] sum;

    loader_cksum u_cksum (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ce && start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR)),
        .add_i  (ce && word_dv && (state_q == ST_LOAD)),
        .data_i (word),
        .sum_o  (sum)
    );
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (ce) begin
            case (state_q)
                // A word arriving with start in these states is dropped, not taken as header.
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (start) begin
                        state_d = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (word_dv) begin
                        if (word == '0 || word > MAX_LEN) begin
                            state_d = ST_ERR;
                        end else begin
                            rem_d   = word[ADDR_W:0];
                            addr_d  = '0;
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_dv) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = word;
                        addr_d      = addr_q + 1'b1;
                        rem_d       = rem_q - 1'b1;
                        if (rem_q == REM_ONE) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CHK;
`else
                            state_d = ST_RUN;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (word_dv) begin
                        state_d = (word == sum) ? ST_RUN : ST_ERR;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // Status follows the next state so it lines up with the final write.
            cpu_rst_q   <= (state_d != ST_RUN);
            busy_q      <= (state_d == ST_HDR) || (state_d == ST_LOAD) || (state_d == ST_CHK);
            done_q      <= (state_d == ST_RUN);
            err_q       <= (state_d == ST_ERR);
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader with ADDR_W=4; adapts to LOADER_CHECKSUM_EN.
module tb_prog_loader;

    localparam int AW = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ce, start, word_dv;
    logic [15:0]   word;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_rst, busy, done, err;

    int n_chk = 0;
    int n_err = 0;
    logic [AW+15:0] exp_q[$];

    prog_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .start     (start),
        .word_dv   (word_dv),
        .word      (word),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    initial begin
        logic [AW+15:0] e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", {12'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[AW+15:16]));
                    chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit tog);
        if (tog) begin
            ce = 1'b0; word_dv = 1'b1; word = ~w;
            @(posedge clk); #1;
            ce = 1'b1; word = w;
            @(posedge clk); #1;
        end else begin
            word_dv = 1'b1; word = w;
            @(posedge clk); #1;
        end
        word_dv = 1'b0;
        ce = 1'b1;
    endtask

    task automatic pulse_start(input bit with_dv);
        start = 1'b1; word_dv = with_dv; word = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0; word_dv = 1'b0;
        chk("busy_on_start", 32'(busy), 1);
        chk("err_on_start", 32'(err), 0);
        chk("cpu_rst_on_start", 32'(cpu_rst), 1);
    endtask

    task automatic load(input int len, input logic [15:0] base, input logic [15:0] step,
                        input bit bad_ck, input bit tog);
        logic [15:0] d;
        logic [15:0] sum;
        sum = 16'h0;
        d   = base;
        send(16'(len), tog);
        for (int i = 0; i < len; i++) begin
            sum = sum + d;
            exp_q.push_back({i[AW-1:0], d});
            send(d, tog);
            d = d + step;
        end
        if (CK) begin
            send(bad_ck ? sum + 16'h1 : sum, tog);
        end
    endtask

    task automatic chk_status(input string tag, input bit exp_done, input bit exp_err);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b0; word_dv = 1'b0; word = 16'h0;
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic load of 0x1111/0x2222/0x3333 with checksum 0x6666.
        pulse_start(1'b0);
        load(3, 16'h1111, 16'h1111, 1'b0, 1'b0);
        chk_status("basic", 1'b1, 1'b0);
        send(16'h5555, 1'b0);
        chk_status("run_ignore", 1'b1, 1'b0);

        // Start with a coincident word: the word is dropped; bad checksum where enabled.
        pulse_start(1'b1);
        load(3, 16'h1111, 16'h1111, 1'b1, 1'b0);
        chk_status("bad_ck", !CK, CK);

        // Zero-length header.
        pulse_start(1'b0);
        send(16'h0000, 1'b0);
        chk_status("hdr_zero", 1'b0, 1'b1);

        // Oversized header, then ignored words in ERR.
        pulse_start(1'b0);
        send(16'h0011, 1'b0);
        chk_status("hdr_big", 1'b0, 1'b1);
        send(16'h0003, 1'b0);
        send(16'h1234, 1'b0);
        chk_status("err_ignore", 1'b0, 1'b1);

        // Full 16-word image, last write at addr 15, nothing wraps to 0.
        pulse_start(1'b0);
        load(16, 16'h0100, 16'h0001, 1'b0, 1'b0);
        chk_status("full", 1'b1, 1'b0);
        send(16'hBEEF, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // ce toggling every cycle, with junk words offered while ce=0.
        pulse_start(1'b0);
        load(3, 16'hA000, 16'h0011, 1'b0, 1'b1);
        chk_status("ce_tog", 1'b1, 1'b0);

        // Asynchronous reset after the second payload word.
        pulse_start(1'b0);
        send(16'h0003, 1'b0);
        exp_q.push_back({4'd0, 16'h0AA0});
        send(16'h0AA0, 1'b0);
        exp_q.push_back({4'd1, 16'h0BB0});
        send(16'h0BB0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        chk("mid_rst_pending", 32'(exp_q.size()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        pulse_start(1'b0);
        load(5, 16'h7000, 16'h0101, 1'b0, 1'b0);
        chk_status("reload", 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
